bidir_bus_port_ctrl: RTL
========================

// Module: bidir_bus_port_ctrl
// PURPOSE
//   Sequencer that sits directly upstream of a tristate pad (tri_io = en ? data : 'z) and
//   consumes the pad readback. Turns a valid/ready request stream into drive/release phases
//   on a shared half-duplex bus, inserts turnaround cycles on direction change and samples
//   read data. Returns one response per request, with contention detection on writes.
// PARAMETERS
//   W         8  bus / data width
//   TURN_CYC  1  idle (released) cycles inserted on every direction change; legal >= 1
//   RD_WAIT   2  strobe cycles of a read; bus sampled at the end of the last one; legal >= 1
// PORTS
//   clk         in     1  clock, all state on rising edge
//   rst_n       in     1  asynchronous active-low reset
//   req_valid   in     1  request present
//   req_ready   out    1  request accepted when req_valid & req_ready
//   req_write   in     1  1 = write, 0 = read
//   req_wdata   in     W  write data
//   rsp_valid   out    1  one-cycle response pulse, no backpressure
//   rsp_rdata   out    W  sampled bus value (read data, or write readback)
//   rsp_err     out    1  write readback mismatch (contention); always 0 for reads
//   bus_io      inout  W  shared bus; driven only while bus_oe = 1, else 'z
//   bus_oe      out    1  registered output enable (observability / pad enable)
//   bus_strobe  out    1  phase-valid strobe to the peer
// BEHAVIOUR
//   - Reset (async, rst_n low): state IDLE, bus_oe=0 (bus_io='z the same instant),
//     bus_strobe=0, req_ready=0 while rst_n low, rsp_valid=0, rsp_rdata=0, rsp_err=0,
//     last_dir=READ. Reset mid-operation aborts the request; no response is ever produced.
//   - States: IDLE, TURN, WRITE, READ. Only IDLE asserts req_ready.
//   - IDLE: on accept, latch req_write/req_wdata. If direction != last_dir -> TURN,
//     else -> WRITE or READ directly. last_dir updates on accept.
//   - TURN: TURN_CYC cycles with bus_oe=0, bus_strobe=0; then -> WRITE or READ.
//   - WRITE: one cycle with bus_oe=1, bus_io=latched wdata, bus_strobe=1. At its closing
//     edge sample bus_io: rsp_rdata<=sample, rsp_err<=(sample !== wdata), rsp_valid<=1; -> IDLE.
//   - READ: RD_WAIT cycles with bus_oe=0, bus_strobe=1; sample bus_io at the closing edge
//     of the last cycle: rsp_rdata<=sample, rsp_err<=0, rsp_valid<=1; -> IDLE.
//   - Latency (same direction): accept edge E0, phase cycle(s), rsp_valid high the cycle after
//     the sampling edge, coincident with req_ready=1; back-to-back accept in that cycle legal.
//     Write: rsp 2 cycles after accept edge; read: RD_WAIT+1; add TURN_CYC on direction change.
//   - bus_oe and bus_io drive are never both asserted with bus_strobe=0 outside WRITE;
//     bus_oe is 0 in every cycle of TURN and READ (no overlap with peer drive).
//   - rsp_valid is a single-cycle pulse; rsp_rdata/rsp_err hold until next response.
//   - Unknown/'z sample bits on a write count as mismatch (case inequality).
//   - Counters for TURN/READ are sized for max(TURN_CYC,RD_WAIT); no wrap within a phase.
// TESTING
//   1 Reset: rst_n low mid-WRITE -> bus_oe=0 and bus_io='z same cycle, no rsp_valid after.
//   2 Write 8'hA5, bus otherwise undriven, last_dir=WRITE -> bus_io=A5 for 1 cycle,
//     rsp_valid 2 cycles after accept, rsp_rdata=A5, rsp_err=0.
//   3 Write 8'h0F while bench weakly/strongly drives 8'hFF -> rsp_err=1, rsp_rdata!=0F.
//   4 Read after reset (no turn), bench drives 8'h3C during strobe -> bus_oe=0 throughout,
//     rsp_rdata=3C at RD_WAIT+1 cycles after accept, rsp_err=0.
//   5 Write then read back-to-back (TURN_CYC=1) -> exactly 1 cycle bus_oe=0,strobe=0
//     between write and read strobes; read rsp at accept+1+RD_WAIT+1.
//   6 req_valid held with 4 alternating ops -> 4 responses in order, req_ready low in every
//     non-IDLE cycle, no cycle where bus_oe=1 adjacent to a read strobe.

Source files
------------

// File: rtl/bidir_bus_port_ctrl.sv
// Half-duplex bus sequencer: turns a valid/ready request stream into drive/release phases
// with turnaround insertion, samples the pad readback and flags write contention.
module bidir_bus_port_ctrl #(
  parameter int unsigned W        = 8,
  parameter int unsigned TURN_CYC = 1,
  parameter int unsigned RD_WAIT  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [W-1:0] req_wdata,
  output logic         rsp_valid,
  output logic [W-1:0] rsp_rdata,
  output logic         rsp_err,
  inout  wire  [W-1:0] bus_io,
  output logic         bus_oe,
  output logic         bus_strobe
);

  localparam int unsigned MaxCyc = (TURN_CYC > RD_WAIT) ? TURN_CYC : RD_WAIT;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam logic [CntW-1:0] TurnLast = CntW'(TURN_CYC - 1);
  localparam logic [CntW-1:0] RdLast   = CntW'(RD_WAIT - 1);

  typedef enum logic [1:0] {StIdle, StTurn, StWrite, StRead} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last_dir_q, last_dir_d;  // 1 = write
  logic            wr_q, wr_d;
  logic [W-1:0]    wdata_q, wdata_d;
  logic            oe_q, oe_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [W-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  // Gated by rst_n so nothing is accepted while reset is held.
  assign req_ready  = (state_q == StIdle) && rst_n;
  assign bus_strobe = (state_q == StWrite) || (state_q == StRead);
  assign bus_oe     = oe_q;
  assign bus_io     = oe_q ? wdata_q : {W{1'bz}};
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_dir_d  = last_dir_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          wr_d       = req_write;
          wdata_d    = req_wdata;
          last_dir_d = req_write;
          cnt_d      = '0;
          if (req_write != last_dir_q) state_d = StTurn;
          else                         state_d = req_write ? StWrite : StRead;
        end
      end
      StTurn: begin
        if (cnt_q == TurnLast) begin
          cnt_d   = '0;
          state_d = wr_q ? StWrite : StRead;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWrite: begin
        // Case inequality so undriven or conflicting bits report as contention.
        rsp_valid_d = 1'b1;
        rsp_rdata_d = bus_io;
        rsp_err_d   = (bus_io !== wdata_q);
        state_d     = StIdle;
      end
      StRead: begin
        if (cnt_q == RdLast) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = bus_io;
          rsp_err_d   = 1'b0;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    oe_d = (state_d == StWrite);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      last_dir_q  <= 1'b0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_dir_q  <= last_dir_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      oe_q        <= oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule
